// File: rtl/quiz_round_ctrl.sv
// Quiz round FSM: accepts latched buzzer winners, runs the answer timer, keeps lockout and saturating scores.
// Build option NEG_SCORE_EN: a judged-wrong answer also decrements the answerer's score (floor 0).
module quiz_round_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int ANSWER_TICKS = 10,
  parameter int SCORE_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_start,
  input  logic                   host_correct,
  input  logic                   host_wrong,
  input  logic                   buzz_valid,
  input  logic [1:0]             buzz_id,
  output logic                   latch_clear,
  output logic [3:0]             lockout,
  output logic                   winner_valid,
  output logic [1:0]             winner,
  output logic [3:0]             timer_val,
  output logic [1:0]             round_state,
  output logic [4*SCORE_W-1:0]   score_bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [3:0]         TIMER_INIT = 4'(ANSWER_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_lockout;
  logic                r_latch_clear;
  logic                r_clr_d;
  logic [1:0]          r_winner;
  logic [3:0]          r_timer;
  logic [PW-1:0]       r_presc;
  logic [SCORE_W-1:0]  r_score [4];

  state_t              w_state_nxt;
  logic [3:0]          w_lock_nxt;
  logic                w_clr_req;
  logic [1:0]          w_winner_nxt;
  logic [3:0]          w_timer_nxt;
  logic [PW-1:0]       w_presc_nxt;
  logic                w_inc;
  logic                w_dec;
  logic                w_buzz_ok;
  logic                w_tick;
  logic [SCORE_W-1:0]  w_score_nxt [4];

  // A buzz is stale while latch_clear is high and for the cycle after, while upstream re-arms.
  assign w_buzz_ok = buzz_valid & ~r_latch_clear & ~r_clr_d;
  assign w_tick    = (r_state == S_ANSWER) && (r_presc == PRESC_MAX);

  always_comb begin
    w_state_nxt  = r_state;
    w_lock_nxt   = r_lockout;
    w_clr_req    = 1'b0;
    w_winner_nxt = r_winner;
    w_timer_nxt  = r_timer;
    w_presc_nxt  = '0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host_start) begin
          w_state_nxt = S_ARMED;
          w_lock_nxt  = 4'b0000;
          w_clr_req   = 1'b1;
        end
      end
      S_ARMED: begin
        if (host_start) begin
          w_lock_nxt = 4'b0000;
          w_clr_req  = 1'b1;
        end else if (w_buzz_ok) begin
          if (r_lockout[buzz_id]) begin
            w_clr_req = 1'b1;
          end else begin
            w_state_nxt  = S_ANSWER;
            w_winner_nxt = buzz_id;
            w_timer_nxt  = TIMER_INIT;
          end
        end
      end
      S_ANSWER: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (host_correct) begin
          w_inc       = 1'b1;
          w_clr_req   = 1'b1;
          w_timer_nxt = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (host_wrong || (w_tick && r_timer == 4'd1)) begin
`ifdef NEG_SCORE_EN
          w_dec = host_wrong;
`endif
          w_lock_nxt[r_winner] = 1'b1;
          w_clr_req   = 1'b1;
          w_timer_nxt = 4'd0;
          w_state_nxt = (&w_lock_nxt) ? S_IDLE : S_ARMED;
        end else if (w_tick) begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_score_nxt = r_score;
    if (w_inc && (r_score[r_winner] != SCORE_MAX))
      w_score_nxt[r_winner] = r_score[r_winner] + 1'b1;
    if (w_dec && (r_score[r_winner] != '0))
      w_score_nxt[r_winner] = r_score[r_winner] - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lockout     <= 4'b0000;
      r_latch_clear <= 1'b0;
      r_clr_d       <= 1'b0;
      r_winner      <= 2'd0;
      r_timer       <= 4'd0;
      r_presc       <= '0;
      for (int i = 0; i < 4; i++) r_score[i] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lockout     <= w_lock_nxt;
      // Back-to-back requests collapse so the pulse never stretches over two cycles.
      r_latch_clear <= w_clr_req & ~r_latch_clear;
      r_clr_d       <= r_latch_clear;
      r_winner      <= w_winner_nxt;
      r_timer       <= w_timer_nxt;
      r_presc       <= w_presc_nxt;
      r_score       <= w_score_nxt;
    end
  end

  assign latch_clear  = r_latch_clear;
  assign lockout      = r_lockout;
  assign winner_valid = (r_state == S_ANSWER);
  assign winner       = r_winner;
  assign timer_val    = r_timer;
  assign round_state  = r_state;

  for (genvar g = 0; g < 4; g++) begin : g_score
    assign score_bus[g*SCORE_W +: SCORE_W] = r_score[g];
  end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Round controller directly downstream of the fastest-finger buzzer latch/encoder stage. It consumes the latched winner code and runs a per-buzz answer timer.
- Host judges each answer. Correct answers add to the player's score. Wrong or timed-out answerers are locked out for the rest of the round.
- Pulses latch_clear to re-arm the upstream latch, and exports lockout so the upstream stage can mask those players.

Parameters:
- TICK_DIV, 50000000, clk cycles per timer tick (1 s at 50 MHz); benches use 4.
- ANSWER_TICKS, 10, answer window in ticks (1..15).
- SCORE_W, 4, per-player score width; saturating.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- host_start  input  1  single-cycle pulse; opens a round.
- host_correct  input  1  single-cycle pulse; current answer accepted.
- host_wrong  input  1  single-cycle pulse; current answer rejected.
- buzz_valid  input  1  high while upstream holds a latched winner.
- buzz_id  input  2  encoded winner, 0..3, valid with buzz_valid.
- latch_clear  output  1  one-cycle pulse; re-arms the upstream latch.
- lockout  output  4  bit i=1: player i barred this round.
- winner_valid  output  1  high in ANSWER state.
- winner  output  2  player currently answering.
- timer_val  output  4  remaining ticks; 0 outside ANSWER.
- round_state  output  2  0 IDLE, 1 ARMED, 2 ANSWER.
- score_bus  output  4*SCORE_W  player i score at [i*SCORE_W +: SCORE_W].

Behaviour:
- Reset (async, rst_n=0) forces IDLE and clears every output: latch_clear=0, lockout=0, winner_valid=0, winner=0, timer_val=0, round_state=0, score_bus=0.
- Tick prescaler counts 0..TICK_DIV-1 and only runs in ANSWER. It restarts at 0 on ANSWER entry, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - host_start goes to ARMED next cycle.
  - On that same edge: lockout cleared, latch_clear pulsed for 1 cycle.
  - host_correct, host_wrong and buzz_valid are ignored.
- ARMED:
  - If buzz_valid=1 and lockout[buzz_id]=0: go to ANSWER. Capture winner=buzz_id, set timer_val=ANSWER_TICKS, winner_valid=1 (registered, 1-cycle latency).
  - If buzz_valid=1 and lockout[buzz_id]=1: stay in ARMED and pulse latch_clear.
  - host_start re-opens the round: lockout cleared, latch_clear pulsed.
- ANSWER:
  - On each tick, timer_val decrements.
  - host_correct: score[winner] increments, saturating at 2^SCORE_W-1. Go to IDLE and pulse latch_clear.
  - host_wrong, or a tick while timer_val=1 (timeout): set lockout[winner]=1 and pulse latch_clear.
    - If all 4 lockout bits are now set, go to IDLE.
    - Otherwise go to ARMED.
  - Leaving ANSWER clears winner_valid and timer_val.
  - host_start is ignored in ANSWER.
- Priority for simultaneous events in ANSWER: host_correct > host_wrong > timeout. Only one action is taken per cycle.
- buzz_valid held high across the latch_clear cycle is ignored in the cycle that follows latch_clear. This gives the upstream stage one cycle to clear.
- latch_clear is never high for 2 consecutive cycles.
- Scores persist across rounds; only reset clears them.

Optional Feature:
- Macro NEG_SCORE_EN.
- Defined: host_wrong also decrements score[winner], saturating at 0. Timeout does not change the score.
- Undefined: scores only increment.

Test Plan:
- Reset with rst_n=0 mid-ANSWER → all outputs 0 immediately (asynchronous), round_state=0; score_bus=0 after release.
- host_start, buzz_valid=1 with buzz_id=2, then host_correct → winner=2, winner_valid=1; score player2=1; latch_clear pulses once after start and once after correct; back to IDLE.
- TICK_DIV=4, ANSWER_TICKS=3, buzz by player 1 with no judge input → timer_val runs 3,2,1 at 4-cycle steps. At the 12th cycle after ANSWER entry: lockout=0010, round_state=1.
- Locked player 1 buzzes again in ARMED → round_state stays 1, one latch_clear pulse. Then player 3 buzzes → ANSWER with winner=3.
- host_wrong on players 0, 1, 2, 3 in turn → lockout=1111, round_state=0. Scores unchanged, or each saturated at 0 with NEG_SCORE_EN.
- host_correct and host_wrong in the same cycle as the final tick → correct wins; score increments and lockout is unchanged. 16 correct answers with SCORE_W=4 → score saturates at 15.
